multicycle_controller: RTL and testbench

- Control FSM for the multicycle RV32I core. It is the driving end of the ALU interface: it produces ALUControl[2:0] and consumes the ALU's Zero flag.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Emits mux selects and write enables for the PC, IR, register file and memory.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

---
 rtl/mc_pkg.sv | 34 +++
 rtl/alu_decoder.sv | 19 +
 rtl/multicycle_controller.sv | 134 +++++++++++++
 tb/tb_multicycle_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, ALU-control and mux-select encodings for the multicycle controller.
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } statetype_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/funct7b5/op[5] to the ALU control code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  // op5 separates R-type sub from addi, whose instr[30] is just immediate bits
  always_comb
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct3 == 3'b000    ? ((funct7b5 & op5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010    ? ALU_SLT :
                  funct3 == 3'b110    ? ALU_OR :
                  funct3 == 3'b111    ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM of the multicycle RV32I core.
// Define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes and expose the illegal flag.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic     illegal
`endif
);
`ifdef MC_ILLEGAL_TRAP_EN
  localparam statetype_t BAD_OP_NEXT = TRAP;
`else
  localparam statetype_t BAD_OP_NEXT = FETCH;
`endif
  statetype_t state, next_state;
  logic [1:0] alu_op;
  logic ready, pc_w, ir_w, reg_w, mem_w;
  assign ready = WAIT_MEM ? mem_ready : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next_state;
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = ready ? DECODE : FETCH;
      DECODE:   next_state = (op == OP_LW || op == OP_SW) ? MEMADR :
                             op == OP_R   ? EXECUTER :
                             op == OP_I   ? EXECUTEI :
                             op == OP_BEQ ? BEQ :
                             op == OP_JAL ? JAL : BAD_OP_NEXT;
      MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = ready ? MEMWB : MEMREAD;
      MEMWRITE: next_state = ready ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RS2;
    alu_op = ALUOP_ADD;
    case (state)
      FETCH: begin
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_w = ready;
        pc_w = ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        alu_op = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op = ALUOP_FUNCT;
      end
      ALUWB: reg_w = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op = ALUOP_SUB;
        pc_w = Zero;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_w = 1'b1;
      end
      default: ;
    endcase
  end
  // state is already FETCH during reset, so only the enables need forcing low
  assign PCWrite = rst_n & pc_w;
  assign IRWrite = rst_n & ir_w;
  assign RegWrite = rst_n & reg_w;
  assign MemWrite = rst_n & mem_w;
  always_comb
    ImmSrc = op == OP_SW  ? IMM_S :
             op == OP_BEQ ? IMM_B :
             op == OP_JAL ? IMM_J : IMM_I;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = state == TRAP;
`endif
  alu_decoder u_alu_decoder (
    .alu_op(alu_op),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .op5(op[5]),
    .alu_control(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized self-checking bench against a per-instruction cycle-table model.
module tb_multicycle_controller;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  typedef struct packed {
    logic wt, zpc, pcw, irw, regw, memw, adr;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
  } step_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal;
`endif
  int checks = 0, passed = 0;
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );
  always #5 clk = ~clk;
  function automatic step_t st(int wt, int zpc, int pcw, int irw, int regw, int memw,
                               int adr, int res, int sa, int sb, int alu);
    return '{1'(wt), 1'(zpc), 1'(pcw), 1'(irw), 1'(regw), 1'(memw), 1'(adr),
             2'(res), 2'(sa), 2'(sb), 3'(alu)};
  endfunction
  function automatic logic [2:0] alu_exp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  // zmode: 0/1 fixed Zero, 2 random; fs/ms: stall cycles at fetch/memory waits; rnd randomizes stalls
  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input int zmode, input int fs, input int ms, input bit rnd);
    step_t q[$];
    logic [2:0] a;
    logic [1:0] imm;
    logic [15:0] obs, expv;
    a = alu_exp(o, f3, f7);
    imm = o == SW ? 2'b01 : o == BQ ? 2'b10 : o == JL ? 2'b11 : 2'b00;
    q.push_back(st(1, 0, 1, 1, 0, 0, 0, 2, 0, 2, 0));
    q.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    if (o == LW || o == SW) q.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    if (o == LW) begin
      q.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      q.push_back(st(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    end
    if (o == SW) q.push_back(st(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    if (o == RT) q.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, int'(a)));
    if (o == IT) q.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, int'(a)));
    if (o == BQ) q.push_back(st(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    if (o == JL) q.push_back(st(0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0));
    if (o == RT || o == IT || o == JL) q.push_back(st(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      int stalls;
      stalls = q[i].wt ? (rnd ? int'($urandom_range(0, 2)) : (i == 0 ? fs : ms)) : 0;
      for (int s = 0; s <= stalls; s++) begin
        step_t e;
        e = q[i];
        @(negedge clk);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        mem_ready = e.wt ? (s == stalls) : 1'($urandom);
        Zero = zmode == 2 ? 1'($urandom) : 1'(zmode);
        #1;
        if (e.wt && !mem_ready) begin
          e.pcw = 1'b0;
          e.irw = 1'b0;
        end
        if (e.zpc) e.pcw = Zero;
        expv = {e.pcw, e.irw, e.regw, e.memw, e.adr, e.res, e.sa, e.sb, e.alu, imm};
        obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
        checks++;
        if (obs !== expv)
          $display("FAIL %s step %0d wait %0d: got pc/ir/rw/mw/adr/res/sa/sb/alu/imm=%b want %b",
                   nm, i, s, obs, expv);
        else passed++;
      end
    end
  endtask
  task automatic test_reset;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000)
        $display("FAIL reset_enables: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    op = RT;
    funct3 = 3'b000;
    funct7b5 = 1'b0;
    #1;
    checks++;
    if ({PCWrite, IRWrite, ALUSrcB} !== 4'b1110)
      $display("FAIL reset_release: got pc/ir/srcb=%b want 1110", {PCWrite, IRWrite, ALUSrcB});
    else passed++;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ALUSrcA, ALUSrcB} !== 4'b1000)
      $display("FAIL reach_executer: got srca/srcb=%b want 1000", {ALUSrcA, ALUSrcB});
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} !== 11'b00000_10_00_10)
      $display("FAIL reset_mid_exec: got %b want 00000100010",
               {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB});
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000)
      $display("FAIL reset_held: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({PCWrite, IRWrite, ALUSrcB} !== 4'b1110)
      $display("FAIL reset_rerelease: got pc/ir/srcb=%b want 1110", {PCWrite, IRWrite, ALUSrcB});
    else passed++;
    mem_ready = 1'b0;
  endtask
  task automatic test_alu_ops;
    run("add", RT, 3'b000, 1'b0, 2, 0, 0, 0);
    run("sub", RT, 3'b000, 1'b1, 2, 0, 0, 0);
    run("and", RT, 3'b111, 1'b0, 2, 0, 0, 0);
    run("or", RT, 3'b110, 1'b0, 2, 0, 0, 0);
    run("slt", RT, 3'b010, 1'b0, 2, 0, 0, 0);
    run("addi_b30", IT, 3'b000, 1'b1, 2, 0, 0, 0);
    run("ori", IT, 3'b110, 1'b1, 2, 0, 0, 0);
    run("slti", IT, 3'b010, 1'b0, 2, 0, 0, 0);
    run("andi", IT, 3'b111, 1'b0, 2, 0, 0, 0);
    run("r_f3_other", RT, 3'b001, 1'b1, 2, 0, 0, 0);
  endtask
  task automatic test_memory;
    run("lw", LW, 3'b010, 1'b0, 2, 0, 0, 0);
    run("lw_stall", LW, 3'b010, 1'b0, 2, 0, 3, 0);
    run("sw", SW, 3'b010, 1'b0, 2, 0, 0, 0);
    run("sw_stall", SW, 3'b010, 1'b1, 2, 2, 2, 0);
  endtask
  task automatic test_branch_jump;
    run("beq_taken", BQ, 3'b000, 1'b0, 1, 0, 0, 0);
    run("beq_not", BQ, 3'b000, 1'b0, 0, 0, 0, 0);
    run("jal", JL, 3'b000, 1'b0, 2, 0, 0, 0);
  endtask
  task automatic test_illegal;
`ifdef MC_ILLEGAL_TRAP_EN
    run("bad_op", 7'b0000000, 3'b000, 1'b0, 2, 0, 0, 0);
    repeat (4) begin
      @(negedge clk);
      mem_ready = 1'b1;
      op = RT;
      #1;
      checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== 5'b00001)
        $display("FAIL trap_hold: got pc/ir/rw/mw/illegal=%b want 00001",
                 {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
      else passed++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) $display("FAIL trap_reset: got illegal=%b want 0", illegal);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
`else
    run("nop_op", 7'b0000000, 3'b000, 1'b0, 2, 0, 0, 0);
    run("nop_op2", 7'b1110011, 3'b000, 1'b1, 2, 0, 0, 0);
`endif
    run("after_bad", RT, 3'b000, 1'b1, 2, 0, 0, 0);
  endtask
  task automatic test_back_to_back;
    logic [6:0] ops [7];
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b0001111};
    for (int n = 0; n < 60; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      int k = int'($urandom_range(0, 5));
`else
      int k = int'($urandom_range(0, 6));
`endif
      run("random", ops[k], 3'($urandom), 1'($urandom), 2, 0, 0, 1);
    end
  endtask
  initial begin
    test_reset();
    test_alu_ops();
    test_memory();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
